// File: rtl/pwm_rx_pkg.sv
// Shared types for the PWM receive path: FSM states, pulse classes and the
// bit positions of the sticky error flags.
package pwm_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DATA
    } state_t;

    typedef enum logic [1:0] {
        SHORT,
        VALID,
        LONG
    } pclass_t;

    localparam int ERR_UNDER = 0;
    localparam int ERR_OVER  = 1;
    localparam int ERR_LONG  = 2;
    localparam int ERR_DROP  = 3;

endpackage

// File: rtl/pwm_width_meter.sv
// Synchronizes the PWM line, detects edges and measures high-pulse width and
// low-gap length in sampling-clock cycles.
module pwm_width_meter #(
    parameter int CNT_W   = 8,
    parameter int GAP_MIN = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    output logic             pulse_done,
    output logic [CNT_W-1:0] width,
    output logic             pulse_long,
    output logic             gap_hit
);

    localparam int               GAP_W   = $clog2(GAP_MIN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'(GAP_MIN);

    logic             s1_reg;
    logic             s2_reg;
    logic             s3_reg;
    logic [CNT_W-1:0] width_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             rise;

    assign rise = s2_reg & ~s3_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            s3_reg    <= 1'b0;
            width_reg <= '0;
            gap_reg   <= '0;
        end else begin
            s1_reg <= in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
            // Rise restarts the count at 1 so the value seen on fall equals the high-cycle count.
            if (rise)
                width_reg <= CNT_W'(1);
            else if (s2_reg && width_reg != CNT_MAX)
                width_reg <= width_reg + 1'b1;
            if (s2_reg)
                gap_reg <= '0;
            else if (gap_reg != GAP_TOP)
                gap_reg <= gap_reg + 1'b1;
        end
    end

    assign pulse_done = ~s2_reg & s3_reg;
    assign width      = width_reg;
    assign pulse_long = (width_reg == CNT_MAX);
    assign gap_hit    = (gap_reg == GAP_TOP);

endmodule

// File: rtl/rx_pwm_decoder.sv
// PWM receiver: frames pulses between idle gaps, calibrates on the first pulse
// and emits (width - reference) as a symbol through a single-entry valid/ready stage.
module rx_pwm_decoder
    import pwm_rx_pkg::*;
#(
    parameter int SYM_W   = 4,
    parameter int CNT_W   = 8,
    parameter int GAP_MIN = 16,
    parameter int MIN_W   = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in,
    output logic [SYM_W-1:0] sym,
    output logic             sym_sof,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] ref_width,
    output logic             frame_active,
    output logic [3:0]       err,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] SYM_MAX = CNT_W'((1 << SYM_W) - 1);

    logic             pulse_done;
    logic [CNT_W-1:0] width;
    logic             pulse_long;
    logic             gap_hit;

    state_t           state_reg;
    logic [SYM_W-1:0] sym_reg;
    logic             sof_reg;
    logic             valid_reg;
    logic             sof_pend_reg;
    logic [CNT_W-1:0] ref_reg;
    logic [3:0]       err_reg;

    pclass_t          pclass;
    logic [CNT_W:0]   diff;
    logic             under;
    logic             over;
    logic [SYM_W-1:0] dec_sym;
    logic             emit;
    logic             drop;
    logic [3:0]       err_set;

    pwm_width_meter #(
        .CNT_W  (CNT_W),
        .GAP_MIN(GAP_MIN)
    ) u_meter (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in),
        .pulse_done(pulse_done),
        .width     (width),
        .pulse_long(pulse_long),
        .gap_hit   (gap_hit)
    );

    always_comb begin
        pclass = VALID;
        if (pulse_long)
            pclass = LONG;
        else if (width < CNT_W'(MIN_W))
            pclass = SHORT;

        // Zero-extended subtraction; the top bit is the sign of width - ref.
        diff  = {1'b0, width} - {1'b0, ref_reg};
        under = diff[CNT_W];
        over  = ~diff[CNT_W] && (diff[CNT_W-1:0] > SYM_MAX);
        if (under)
            dec_sym = '0;
        else if (over)
            dec_sym = '1;
        else
            dec_sym = diff[SYM_W-1:0];

        emit = pulse_done && (pclass == VALID) && (state_reg == DATA);
        drop = emit && valid_reg && !sym_ready;

        err_set            = '0;
        err_set[ERR_UNDER] = emit && under;
        err_set[ERR_OVER]  = emit && over;
        err_set[ERR_LONG]  = pulse_done && (pclass == LONG);
        err_set[ERR_DROP]  = drop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            sym_reg      <= '0;
            sof_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            sof_pend_reg <= 1'b0;
            ref_reg      <= '0;
            err_reg      <= '0;
        end else begin
            err_reg <= (err_clr ? 4'b0000 : err_reg) | err_set;

            if (pulse_done && pclass == LONG) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: if (gap_hit) state_reg <= ARMED;
                    ARMED: begin
                        if (pulse_done && pclass == VALID) begin
                            ref_reg      <= width;
                            sof_pend_reg <= 1'b1;
                            state_reg    <= DATA;
                        end
                    end
                    DATA: if (gap_hit) state_reg <= ARMED;
                    default: state_reg <= IDLE;
                endcase
            end

            if (emit && !drop) begin
                sym_reg      <= dec_sym;
                sof_reg      <= sof_pend_reg;
                valid_reg    <= 1'b1;
                sof_pend_reg <= 1'b0;
            end else if (valid_reg && sym_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign sym          = sym_reg;
    assign sym_sof      = sof_reg;
    assign sym_valid    = valid_reg;
    assign ref_width    = ref_reg;
    assign frame_active = (state_reg == DATA);
    assign err          = err_reg;

endmodule

// File: tb/tb_rx_pwm_decoder.sv
// Scenario bench for rx_pwm_decoder: expected symbols are queued as pulses are
// driven and popped by a monitor at each handshake.
`timescale 1ns/1ps
module tb_rx_pwm_decoder;

    typedef struct {
        logic [3:0] s;
        logic       sof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in;
    logic [3:0] sym;
    logic       sym_sof;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] ref_width;
    logic       frame_active;
    logic [3:0] err;
    logic       err_clr;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    rx_pwm_decoder #(
        .SYM_W  (4),
        .CNT_W  (8),
        .GAP_MIN(16),
        .MIN_W  (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in          (in),
        .sym         (sym),
        .sym_sof     (sym_sof),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .ref_width   (ref_width),
        .frame_active(frame_active),
        .err         (err),
        .err_clr     (err_clr)
    );

    always @(negedge clk) begin
        if (rstn && sym_valid && sym_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sym: got sym=%0d sof=%0d, required no symbol", sym, sym_sof);
            end else begin
                mon_e = sb.pop_front();
                if (sym !== mon_e.s || sym_sof !== mon_e.sof) begin
                    errors++;
                    $display("FAIL sym_value: got sym=%0d sof=%0d, required sym=%0d sof=%0d",
                             sym, sym_sof, mon_e.s, mon_e.sof);
                end else begin
                    $display("symbol sym=%0d sof=%0d accepted", sym, sym_sof);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        in = 1'b0;
        repeat (n) @(posedge clk) #1;
    endtask

    task automatic pulse(input int w);
        in = 1'b1;
        repeat (w) @(posedge clk) #1;
        in = 1'b0;
    endtask

    task automatic push(input logic [3:0] s, input logic sof);
        exp_t e;
        e.s   = s;
        e.sof = sof;
        sb.push_back(e);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk) #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in = 1'b0; sym_ready = 1'b1; err_clr = 1'b0;
        #25;
        checks++; if (sym !== 4'd0) begin errors++; $display("FAIL reset_sym: got %0d, required 0", sym); end
        checks++; if (sym_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %0b, required 0", sym_sof); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", sym_valid); end
        checks++; if (ref_width !== 8'd0) begin errors++; $display("FAIL reset_ref: got %0d, required 0", ref_width); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b, required 0", frame_active); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b, required 0000", err); end
        @(posedge clk) #1;
        rstn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        idle(20);
        pulse(7);  idle(4);
        pulse(7);  push(4'd0, 1'b1); idle(4);
        pulse(10); push(4'd3, 1'b0); idle(4);
        pulse(22); push(4'd15, 1'b0); idle(4);
        checks++; if (ref_width !== 8'd7) begin errors++; $display("FAIL basic_ref: got %0d, required 7", ref_width); end
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL basic_active: got %0b, required 1", frame_active); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL basic_err: got %b, required 0000", err); end
        idle(20);
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL basic_gap_end: got %0b, required 0", frame_active); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_under_over();
        pulse(7);  idle(4);
        pulse(5);  push(4'd0, 1'b1); idle(4);
        pulse(30); push(4'd15, 1'b0); idle(4);
        checks++; if (err !== 4'b0011) begin errors++; $display("FAIL uo_err: got %b, required 0011", err); end
        clear_err();
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL uo_clear: got %b, required 0000", err); end
        idle(20);
    endtask

    task automatic test_glitch();
        pulse(7); idle(4);
        pulse(1); idle(3);
        pulse(9); push(4'd2, 1'b1); idle(4);
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL glitch_active: got %0b, required 1", frame_active); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL glitch_err: got %b, required 0000", err); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL glitch_pending: got %0d left, required 0", sb.size()); end
        idle(20);
    endtask

    task automatic test_back_to_back();
        pulse(7); idle(4);
        sym_ready = 1'b0;
        pulse(8); push(4'd1, 1'b1);
        // Line sampled low at the next edge N; valid must appear after N+2.
        @(posedge clk) #1;
        @(posedge clk) #1;
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%0b, required 0", sym_valid); end
        @(posedge clk) #1;
        checks++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL latency_n2: got valid=%0b, required 1", sym_valid); end
        idle(3);
        pulse(9); idle(6);
        checks++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL drop_valid: got %0b, required 1", sym_valid); end
        checks++; if (sym !== 4'd1) begin errors++; $display("FAIL drop_held_sym: got %0d, required 1", sym); end
        checks++; if (sym_sof !== 1'b1) begin errors++; $display("FAIL drop_held_sof: got %0b, required 1", sym_sof); end
        checks++; if (err !== 4'b1000) begin errors++; $display("FAIL drop_err: got %b, required 1000", err); end
        sym_ready = 1'b1;
        idle(3);
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL drop_after: got valid=%0b, required 0", sym_valid); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL drop_pending: got %0d left, required 0", sb.size()); end
        idle(20);
        clear_err();
    endtask

    task automatic test_long();
        pulse(7); idle(4);
        pulse(8); push(4'd1, 1'b1); idle(4);
        pulse(300); idle(3);
        checks++; if (err[2] !== 1'b1) begin errors++; $display("FAIL long_err: got %b, required bit2 set", err); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL long_active: got %0b, required 0", frame_active); end
        idle(7);
        pulse(7); idle(20);
        pulse(12); idle(4);
        pulse(15); push(4'd3, 1'b1); idle(4);
        checks++; if (ref_width !== 8'd12) begin errors++; $display("FAIL long_recal: got %0d, required 12", ref_width); end
        idle(20);
        clear_err();
    endtask

    task automatic test_reset_mid();
        pulse(7); idle(4);
        sym_ready = 1'b0;
        pulse(8); idle(4);
        checks++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got valid=%0b, required 1", sym_valid); end
        rstn = 1'b0;
        #1;
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b, required 0", sym_valid); end
        checks++; if (sym !== 4'd0 || sym_sof !== 1'b0) begin errors++; $display("FAIL rmid_sym: got sym=%0d sof=%0b, required 0 0", sym, sym_sof); end
        checks++; if (ref_width !== 8'd0) begin errors++; $display("FAIL rmid_ref: got %0d, required 0", ref_width); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL rmid_active: got %0b, required 0", frame_active); end
        @(posedge clk) #1;
        rstn = 1'b1;
        sym_ready = 1'b1;
        idle(5);
        pulse(7); idle(20);
        pulse(9); idle(4);
        pulse(11); push(4'd2, 1'b1); idle(20);
        checks++; if (ref_width !== 8'd9) begin errors++; $display("FAIL rmid_recal: got %0d, required 9", ref_width); end
        checks++; if (err !== 4'b0000) begin errors++; $display("FAIL rmid_err: got %b, required 0000", err); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_pending: got %0d left, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_under_over();
        test_glitch();
        test_back_to_back();
        test_long();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_pwm_decoder.md
# rx_pwm_decoder

Receive-side counterpart of the PWM transmit driver: samples the digitized PWM line (comparator/slicer output) on a sampling clock whose period equals the transmitter's `Tunit` step, measures every high-pulse width in clock cycles, and decodes it into a symbol. Frames are delimited by line-idle gaps. The first pulse of each frame is a calibration pulse whose width becomes the zero-code reference. Decoded symbols leave through a valid/ready interface toward the link-layer deserializer.

## Interface
Parameters:
- `SYM_W` = 4: symbol width in bits; max code `2^SYM_W-1`.
- `CNT_W` = 8: width-counter bits; saturates at `2^CNT_W-1`.
- `GAP_MIN` = 16: consecutive low cycles that end or arm a frame.
- `MIN_W` = 2: pulses narrower than this many cycles are glitches and are ignored.

Ports:
- `clk` input, 1: sampling clock, one period per `Tunit`.
- `rstn` input, 1: asynchronous, active-low reset.
- `in` input, 1: raw PWM line, asynchronous to `clk`.
- `sym` output, SYM_W: decoded symbol.
- `sym_sof` output, 1: `sym` is the first data symbol of its frame.
- `sym_valid` output, 1: `sym`/`sym_sof` valid.
- `sym_ready` input, 1: consumer accepts when high together with `sym_valid`.
- `ref_width` output, CNT_W: current calibration width.
- `frame_active` output, 1: FSM is in DATA.
- `err` output, 4: sticky flags {drop, long, over, under} (bits 3..0).
- `err_clr` input, 1: synchronous clear of `err`.

## Operation
- Input path: 2-flop synchronizer (`s1`,`s2`), then history flop `s3`. rise = `s2 & ~s3`; fall = `~s2 & s3`.
- Width counter: loads 1 on rise and increments while `s2`=1, saturating. On fall, width W = counter value.
- Gap counter: cleared while `s2`=1; increments while `s2`=0, saturating at GAP_MIN.
- Pulse classes on fall: short (W < MIN_W) is ignored everywhere with no state change. Long (counter saturated) sets `err[2]` and forces the FSM to IDLE. Otherwise the pulse is valid.
- FSM states: IDLE, ARMED, DATA.
  - IDLE -> ARMED when gap counter reaches GAP_MIN.
  - ARMED: a valid pulse loads `ref_width`=W and moves to DATA; the next symbol gets `sym_sof`=1.
  - DATA: each valid pulse emits a symbol. Gap counter reaching GAP_MIN -> ARMED.
  - Any state: long pulse -> IDLE.
- Symbol arithmetic uses D = W - `ref_width` in CNT_W+1 signed bits.
  - D<0: `sym`=0, set `err[0]`.
  - D>2^SYM_W-1: `sym`=all-ones, set `err[1]`.
  - Otherwise `sym`=D[SYM_W-1:0].
- Output register: a single entry.
  - If `sym_valid`=1 and `sym_ready`=0 when a new symbol is decoded, the new symbol is dropped, `err[3]` is set, and the held symbol is unchanged.
  - A decode in the same cycle as acceptance (`sym_valid & sym_ready`) loads the new symbol with no drop.
- `err_clr` clears all flags. A flag set in the same cycle as `err_clr` wins and stays set.

## Timing
- Reset values: `sym`=0, `sym_sof`=0, `sym_valid`=0, `ref_width`=0, `frame_active`=0, `err`=0, FSM=IDLE, all counters and sync flops 0.
- After reset, a full GAP_MIN low-cycle run is needed before the first frame is accepted. A line held high at reset stays in IDLE.
- Latency: `in` falls before clk edge N (sampled low at N). The fall is detected after edge N+1, and `sym_valid` is high after edge N+2.
- Width resolution is ±1 cycle (asynchronous sampling). The synchronizer delays rise and fall equally, so W is unbiased.
- `sym_valid` holds until handshake. `sym`/`sym_sof` are stable while `sym_valid & ~sym_ready`.
- `ref_width` updates on the cycle the calibration fall is processed. It holds until the next calibration or reset.
- `frame_active` is high exactly while FSM=DATA.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). A pending symbol is lost without setting drop.

## Structure
- Package `pwm_rx_pkg`:
  - FSM state enum (IDLE, ARMED, DATA).
  - Error-bit index localparams (ERR_UNDER=0, ERR_OVER=1, ERR_LONG=2, ERR_DROP=3).
  - Pulse-class enum (SHORT, VALID, LONG).
- Sub-module `pwm_width_meter`: synchronizer, edge detect, width counter, gap counter. Outputs `pulse_done`, `width`, `pulse_long`, `gap_hit`.
- Top `rx_pwm_decoder`: FSM, arithmetic, output register, error flags.

## Test plan
- Reset, 20 low cycles, calibration pulse 7 cycles, data pulses 7, 10, 22 cycles, `sym_ready`=1 -> `ref_width`=7; symbols 0 (sof=1), 3, 15; `err`=0.
- Same frame with a data pulse of 5 cycles and another of 30 cycles -> symbols 0 and 15; `err`=4'b0011.
- 1-cycle glitch between data pulses, then a 9-cycle pulse -> glitch ignored; single symbol 2; FSM stays DATA.
- `sym_ready`=0 across two data pulses (widths 8, 9) -> `sym`=1 held; second symbol dropped; `err[3]`=1; after `sym_ready`=1, one handshake only.
- Pulse held high 300 cycles mid-frame -> `err[2]`=1, FSM IDLE, `frame_active`=0. The next frame is decoded only after 16 low cycles; the new calibration sets fresh `ref_width`.
- `rstn` low mid-frame with `sym_valid`=1 -> all outputs 0 immediately. After release, 16 low cycles plus a new calibration are needed before output.
